// File: rtl/pll_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for and qualifies lock with bounded
// retry, then releases the downstream domain resets one after another.
module pll_supervisor #(
    parameter int N_OUT         = 2,
    parameter int LOCK_STABLE   = 1024,
    parameter int STAGGER       = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int PLLRST_CYCLES = 8,
    parameter int MAX_RETRY     = 3,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic [N_OUT-1:0] rst_out,
    output logic             ready,
    output logic             fault,
    output logic             lock_lost,
    output logic [RW-1:0]    retry_count
);

    localparam int M1   = (LOCK_STABLE > STAGGER) ? LOCK_STABLE : STAGGER;
    localparam int M2   = (LOCK_TIMEOUT > PLLRST_CYCLES) ? LOCK_TIMEOUT : PLLRST_CYCLES;
    localparam int CMAX = (M1 > M2) ? M1 : M2;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int IW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [2:0] {
        PLLRST, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [IW-1:0]    idx, idx_n;
    logic [RW-1:0]    retries, retries_n;
    logic [N_OUT-1:0] rst_out_n;
    logic             pll_rst_n, ready_n, fault_n, lock_lost_n;
    logic             sync1, locked_s;

    assign retry_count = retries;

    always_ff @(posedge clkin) begin
        if (rst) begin
            state     <= PLLRST;
            cnt       <= '0;
            idx       <= '0;
            retries   <= '0;
            sync1     <= 1'b0;
            locked_s  <= 1'b0;
            pll_rst   <= 1'b1;
            rst_out   <= '1;
            ready     <= 1'b0;
            fault     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            retries   <= retries_n;
            sync1     <= pll_locked;
            locked_s  <= sync1;
            pll_rst   <= pll_rst_n;
            rst_out   <= rst_out_n;
            ready     <= ready_n;
            fault     <= fault_n;
            lock_lost <= lock_lost_n;
        end
    end

    // Outputs are computed as next-register values so every output is a flop.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        retries_n   = retries;
        rst_out_n   = rst_out;
        pll_rst_n   = 1'b0;
        ready_n     = ready;
        fault_n     = 1'b0;
        lock_lost_n = 1'b0;
        case (state)
            PLLRST: begin
                pll_rst_n = 1'b1;
                rst_out_n = '1;
                ready_n   = 1'b0;
                if (cnt == CW'(PLLRST_CYCLES - 1)) begin
                    state_n   = WAIT_LOCK;
                    cnt_n     = '0;
                    pll_rst_n = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                rst_out_n = '1;
                ready_n   = 1'b0;
                if (locked_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    cnt_n = '0;
                    if (retries == RW'(MAX_RETRY)) begin
                        state_n = FAULT;
                        fault_n = 1'b1;
                    end else begin
                        retries_n = retries + 1'b1;
                        state_n   = PLLRST;
                        pll_rst_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == CW'(LOCK_STABLE - 1)) begin
                    cnt_n = '0;
                    if (N_OUT == 1) begin
                        state_n   = RUN;
                        rst_out_n = '0;
                        ready_n   = 1'b1;
                        retries_n = '0;
                    end else begin
                        state_n      = RELEASE;
                        rst_out_n[0] = 1'b0;
                        idx_n        = IW'(1);
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RELEASE, RUN: begin
                // Lock loss pulls every domain back into reset and waits for relock.
                if (!locked_s) begin
                    state_n     = WAIT_LOCK;
                    cnt_n       = '0;
                    idx_n       = '0;
                    rst_out_n   = '1;
                    ready_n     = 1'b0;
                    lock_lost_n = 1'b1;
                end else if (state == RUN) begin
                    rst_out_n = '0;
                    ready_n   = 1'b1;
                end else if (cnt == CW'(STAGGER - 1)) begin
                    cnt_n          = '0;
                    rst_out_n[idx] = 1'b0;
                    idx_n          = idx + 1'b1;
                    if (idx == IW'(N_OUT - 1)) begin
                        state_n   = RUN;
                        ready_n   = 1'b1;
                        retries_n = '0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            FAULT: begin
                fault_n   = 1'b1;
                rst_out_n = '1;
                ready_n   = 1'b0;
            end
            default: begin
                state_n = PLLRST;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor: a three-channel instance covers the full sequence,
// a single-channel instance covers the direct STABLE-to-RUN release.
module tb_pll_supervisor;

    logic       clkin;
    logic       rst, pll_locked;
    logic       pll_rst, ready, fault, lock_lost;
    logic [2:0] rst_out;
    logic [1:0] retry_count;

    logic       rst1, lock1;
    logic       pll_rst1, ready1, fault1, lock_lost1;
    logic [0:0] rst_out1;
    logic [1:0] retry_count1;

    int asserts  = 0;
    int failures = 0;
    int n;

    pll_supervisor #(
        .N_OUT(3), .LOCK_STABLE(16), .STAGGER(4),
        .LOCK_TIMEOUT(32), .PLLRST_CYCLES(8), .MAX_RETRY(2)
    ) dut (
        .clkin(clkin), .rst(rst), .pll_locked(pll_locked),
        .pll_rst(pll_rst), .rst_out(rst_out), .ready(ready), .fault(fault),
        .lock_lost(lock_lost), .retry_count(retry_count)
    );

    pll_supervisor #(
        .N_OUT(1), .LOCK_STABLE(16), .STAGGER(4),
        .LOCK_TIMEOUT(32), .PLLRST_CYCLES(8), .MAX_RETRY(2)
    ) dut1 (
        .clkin(clkin), .rst(rst1), .pll_locked(lock1),
        .pll_rst(pll_rst1), .rst_out(rst_out1), .ready(ready1), .fault(fault1),
        .lock_lost(lock_lost1), .retry_count(retry_count1)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Inputs change on the falling edge so each rising edge samples settled values.
    task automatic applyStimulus(input logic r, input logic lk, input int cycles);
        rst        = r;
        pll_locked = lk;
        repeat (cycles) @(negedge clkin);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        asserts++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst1  = 1'b1;
        lock1 = 1'b0;
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("reset_pll_rst",   32'(pll_rst),     32'd1);
        checkOutput("reset_rst_out",   32'(rst_out),     32'h7);
        checkOutput("reset_ready",     32'(ready),       32'd0);
        checkOutput("reset_fault",     32'(fault),       32'd0);
        checkOutput("reset_lock_lost", 32'(lock_lost),   32'd0);
        checkOutput("reset_retry",     32'(retry_count), 32'd0);

        rst = 1'b0;
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin
            n++;
            applyStimulus(1'b0, 1'b0, 1);
        end
        checkOutput("pllrst_width_first", 32'(n), 32'd8);

        // Nominal: lock 5 cycles after pll_rst falls; edge t samples the first high.
        applyStimulus(1'b0, 1'b0, 5);
        applyStimulus(1'b0, 1'b1, 18);
        checkOutput("nom_t17", 32'(rst_out), 32'h7);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("nom_t18", 32'(rst_out), 32'h6);
        applyStimulus(1'b0, 1'b1, 3);
        checkOutput("nom_t21", 32'(rst_out), 32'h6);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("nom_t22", 32'(rst_out), 32'h4);
        checkOutput("nom_t22_ready", 32'(ready), 32'd0);
        applyStimulus(1'b0, 1'b1, 3);
        checkOutput("nom_t25", 32'(rst_out), 32'h4);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("nom_t26", 32'(rst_out), 32'h0);
        checkOutput("nom_t26_ready", 32'(ready), 32'd1);
        checkOutput("nom_retry", 32'(retry_count), 32'd0);

        // Lock loss in RUN: low sampled at edge u, reaction at u+2.
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("loss_u1_rst_out", 32'(rst_out), 32'h0);
        checkOutput("loss_u1_ready", 32'(ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("loss_u2_rst_out", 32'(rst_out), 32'h7);
        checkOutput("loss_u2_ready", 32'(ready), 32'd0);
        checkOutput("loss_u2_pulse", 32'(lock_lost), 32'd1);
        checkOutput("loss_u2_pll_rst", 32'(pll_rst), 32'd0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("loss_u3_pulse", 32'(lock_lost), 32'd0);

        // Relock, then a one-cycle glitch at STABLE cycle 10 restarts the window.
        applyStimulus(1'b0, 1'b1, 13);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 5);
        checkOutput("glitch_no_release", 32'(rst_out), 32'h7);
        applyStimulus(1'b0, 1'b1, 13);
        checkOutput("glitch_t17", 32'(rst_out), 32'h7);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("glitch_t18", 32'(rst_out), 32'h6);
        applyStimulus(1'b0, 1'b1, 8);
        checkOutput("glitch_t26", 32'(rst_out), 32'h0);
        checkOutput("glitch_t26_ready", 32'(ready), 32'd1);

        // Reset while RELEASE is under way.
        applyStimulus(1'b0, 1'b0, 3);
        applyStimulus(1'b0, 1'b1, 19);
        checkOutput("midrel_started", 32'(rst_out), 32'h6);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("midrel_rst_out", 32'(rst_out), 32'h7);
        checkOutput("midrel_pll_rst", 32'(pll_rst), 32'd1);
        checkOutput("midrel_ready", 32'(ready), 32'd0);
        checkOutput("midrel_retry", 32'(retry_count), 32'd0);

        // Lock never arrives: three pulses, two retries, then FAULT.
        rst = 1'b0;
        for (int p = 0; p < 3; p++) begin
            checkOutput($sformatf("timeout_retry_%0d", p), 32'(retry_count), 32'(p));
            n = 0;
            while (pll_rst === 1'b1 && n < 100) begin
                n++;
                applyStimulus(1'b0, 1'b0, 1);
            end
            checkOutput($sformatf("timeout_pulse_%0d", p), 32'(n), 32'd8);
            n = 0;
            while (pll_rst === 1'b0 && fault === 1'b0 && n < 200) begin
                n++;
                applyStimulus(1'b0, 1'b0, 1);
            end
            checkOutput($sformatf("timeout_wait_%0d", p), 32'(n), 32'd32);
        end
        checkOutput("fault_set", 32'(fault), 32'd1);
        checkOutput("fault_pll_rst", 32'(pll_rst), 32'd0);
        checkOutput("fault_rst_out", 32'(rst_out), 32'h7);
        checkOutput("fault_retry", 32'(retry_count), 32'd2);
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("fault_sticky", 32'(fault), 32'd1);
        checkOutput("fault_sticky_rst_out", 32'(rst_out), 32'h7);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("fault_cleared", 32'(fault), 32'd0);

        // Single channel: rst_out[0] and ready move together.
        checkOutput("n1_reset_rst_out", 32'(rst_out1), 32'd1);
        checkOutput("n1_reset_ready", 32'(ready1), 32'd0);
        rst1 = 1'b0;
        n = 0;
        while (pll_rst1 === 1'b1 && n < 100) begin
            n++;
            applyStimulus(1'b1, 1'b0, 1);
        end
        checkOutput("n1_pllrst_width", 32'(n), 32'd8);
        applyStimulus(1'b1, 1'b0, 2);
        lock1 = 1'b1;
        applyStimulus(1'b1, 1'b0, 18);
        checkOutput("n1_t17_rst_out", 32'(rst_out1), 32'd1);
        checkOutput("n1_t17_ready", 32'(ready1), 32'd0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("n1_t18_rst_out", 32'(rst_out1), 32'd0);
        checkOutput("n1_t18_ready", 32'(ready1), 32'd1);
        lock1 = 1'b0;
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("n1_loss_rst_out", 32'(rst_out1), 32'd1);
        checkOutput("n1_loss_ready", 32'(ready1), 32'd0);
        checkOutput("n1_loss_pulse", 32'(lock_lost1), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Parametrised PLL lock supervisor and multi-domain reset sequencer, the successor to the fixed single-PLL wrapper. Runs in the PLL reference-clock domain. It pulses the PLL reset, waits for lock with timeout and bounded retry, and qualifies lock over a stable window. It then releases N downstream domain resets in a staggered order and re-asserts them all on lock loss. Sits between the ECP5 EHXPLLL instance and the NES core, video and audio reset inputs.

## Interface
- N_OUT, 2: number of downstream reset channels (1..8).
- LOCK_STABLE, 1024: consecutive synchronised-lock cycles required before the first release (≥1).
- STAGGER, 16: cycles between successive channel releases (≥1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a PLL reset retry (≥1).
- PLLRST_CYCLES, 8: width of each pll_rst pulse (≥1).
- MAX_RETRY, 3: PLL reset retries before FAULT (≥0).

- clkin  in  1  PLL reference clock (25 MHz); the only clock.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  raw PLL LOCK, asynchronous; 2-flop synchronised internally (locked_s).
- pll_rst  out  1  PLL RST, active-high.
- rst_out  out  N_OUT  active-high domain resets; released in index order 0..N_OUT-1; consumers re-synchronise.
- ready  out  1  high in RUN only.
- fault  out  1  sticky; high in FAULT only.
- lock_lost  out  1  one-cycle pulse on lock loss during RELEASE or RUN.
- retry_count  out  clog2(MAX_RETRY+1)  retries used since the last RUN entry or rst.

## Operation
- States: PLLRST, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT. Single counter cnt, width clog2 of the largest parameter, plus release index idx and a retry counter.
- rst: state←PLLRST, cnt←0, idx←0, retries←0, sync flops←0, pll_rst=1, rst_out=all 1s, ready=0, fault=0, lock_lost=0.
- PLLRST: pll_rst=1; after PLLRST_CYCLES cycles in state go to WAIT_LOCK, cnt←0.
- WAIT_LOCK: pll_rst=0, rst_out all 1s.
  - locked_s=1 → STABLE, cnt←0.
  - Otherwise cnt++. At LOCK_TIMEOUT cycles: if retries==MAX_RETRY → FAULT, else retries++ → PLLRST, cnt←0.
- STABLE: locked_s=0 → WAIT_LOCK, cnt←0, retries unchanged. At LOCK_STABLE cycles with lock held → RELEASE: rst_out[0]←0 on the transition edge, idx←1, cnt←0.
- RELEASE: every STAGGER cycles clear rst_out[idx], idx++. The edge clearing rst_out[N_OUT-1] also enters RUN, sets ready=1 and retries←0. With N_OUT=1, STABLE goes directly to RUN on the same edge.
- RUN: steady state; rst_out all 0s.
- Lock loss (locked_s=0) in RELEASE or RUN:
  - Next edge: rst_out all 1s, ready=0, lock_lost=1 for one cycle.
  - → WAIT_LOCK, cnt←0, idx←0. No PLL reset is issued until timeout.
- FAULT: pll_rst=0, rst_out all 1s, fault=1; pll_locked ignored; exit only via rst.
- rst asserted in any state, including mid-RELEASE, returns to the rst values on the next edge.

## Timing
- Synchroniser: pll_locked sampled high at edge t gives locked_s high after edge t+1; STABLE entered at edge t+2.
- rst_out[0] falls at edge t+2+LOCK_STABLE. rst_out[k] falls at edge t+2+LOCK_STABLE+k·STAGGER. ready rises with rst_out[N_OUT-1].
- Lock loss: pll_locked low at edge u gives all rst_out high and lock_lost pulse at edge u+2.
- pll_rst is high for exactly PLLRST_CYCLES cycles per pulse, first pulse starting on the cycle after rst deasserts.
- WAIT_LOCK timeout fires on the LOCK_TIMEOUT-th edge after entry.
- All outputs are registered; no combinational path from pll_locked to any output.

## Test plan
- Nominal (N_OUT=3, LOCK_STABLE=16, STAGGER=4): pll_locked high 5 cycles after pll_rst falls → rst_out bits fall at 18, 22 and 26 edges after the first high sample; ready=1 at 26; retry_count=0.
- Lock glitch in STABLE: drop pll_locked 1 cycle at STABLE cycle 10 → return to WAIT_LOCK, full LOCK_STABLE window restarts, rst_out stays all 1s.
- Timeout/retry (LOCK_TIMEOUT=32, MAX_RETRY=2): lock never asserts → 3 pll_rst pulses of PLLRST_CYCLES each, retry_count 0→1→2, then fault=1, pll_rst=0, rst_out all 1s until rst.
- Lock loss in RUN: drop pll_locked → 2 edges later rst_out=111, ready=0, single lock_lost pulse; on relock, staggered release repeats.
- rst mid-RELEASE, after rst_out[0] has fallen → next edge rst_out=111, pll_rst=1, state PLLRST, retry_count=0.
- N_OUT=1: rst_out[0] and ready rise/fall on the same edge, at LOCK_STABLE+2 edges after the first high sample.
